// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
//   muldiv_op_t : request opcode coming from decode
//   md_state_t  : sequencer states
//   XLEN        : architectural register width
//   CNT_W       : width of the shared latency / iteration counter
//   DIV_ZERO_LO : quotient reported for a divide by zero
//   mag32()     : two's-complement magnitude of a 32-bit operand
package hilo_muldiv_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [XLEN-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    // State names carry an _S_ infix so they cannot clash with the MD_DIV opcode.
    typedef enum logic [1:0] {
        MD_S_IDLE = 2'd0,
        MD_S_MUL  = 2'd1,
        MD_S_DIV  = 2'd2,
        MD_S_SIGN = 2'd3
    } md_state_t;

    // Negating 0x8000_0000 wraps to itself, which read as unsigned is the
    // correct magnitude 2^31.
    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (XLEN'(0) - v) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// One combinational restoring-division step.
//   rem_i/quo_i : partial remainder and dividend/quotient shift register in
//   divisor_i   : unsigned divisor magnitude
//   rem_o/quo_o : state after shifting one dividend bit in and trying a subtract
module hilo_muldiv_ctrl_div_step
    import hilo_muldiv_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign fits    = (shifted >= {1'b0, divisor_i});

    // After a successful subtract the result is below the divisor, so it fits XLEN bits.
    assign rem_o = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Owner and sequencer of the HI/LO register pair.
//   clk, reset       : clock, asynchronous active-high reset
//   req_valid/op/a/b : request from decode; accepted when req_valid & req_ready
//   req_ready        : IDLE and no flush
//   flush            : abort any in-flight multiply/divide without committing
//   busy             : multiply/divide in flight
//   done             : one-cycle pulse when HI/LO take a MUL/DIV result
//   hi, lo           : architectural HI/LO
// MUL_LAT (1..8) sets accept-to-commit cycles for multiplies; DIV_STEPS (1,2,4)
// sets restoring steps per cycle, giving 32/DIV_STEPS + 1 cycles per divide.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DIV_STEPS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  muldiv_op_t      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            req_ready,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(XLEN / DIV_STEPS - 1);

    md_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   rem_q, quo_q, divisor_q;
    logic              neg_quo_q, neg_rem_q, div_zero_q;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              done_q;

    logic              accept;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod_d;
    logic              div_signed, div_zero_d;

    assign accept = req_valid & req_ready;

    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        mul_a_ext = {{XLEN{1'b0}}, req_a};
        mul_b_ext = {{XLEN{1'b0}}, req_b};
        if (req_op == MD_MULT) begin
            mul_a_ext = {{XLEN{req_a[XLEN-1]}}, req_a};
            mul_b_ext = {{XLEN{req_b[XLEN-1]}}, req_b};
        end
    end

    // Low 2*XLEN bits of the extended product are exact for signed and unsigned.
    assign prod_d     = mul_a_ext * mul_b_ext;
    assign div_signed = (req_op == MD_DIV);
    assign div_zero_d = (req_b == '0);

    // DIV_STEPS restoring steps chained combinationally each DIV cycle.
    logic [XLEN-1:0] rem_chain [DIV_STEPS+1];
    logic [XLEN-1:0] quo_chain [DIV_STEPS+1];

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar g = 0; g < DIV_STEPS; g++) begin : g_step
        hilo_muldiv_ctrl_div_step u_step (
            .rem_i     (rem_chain[g]),
            .quo_i     (quo_chain[g]),
            .divisor_i (divisor_q),
            .rem_o     (rem_chain[g+1]),
            .quo_o     (quo_chain[g+1])
        );
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: datapath registers are plain flops, not memory, so they share the
    // async reset; this keeps X out of hi/lo and the divider after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MD_S_IDLE;
            cnt_q      <= '0;
            prod_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_S_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            MD_MULT, MD_MULTU: begin
                                prod_q  <= prod_d;
                                cnt_q   <= MUL_CNT_INIT;
                                state_q <= MD_S_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                // Divide by zero runs unsigned on the raw dividend: a
                                // zero divisor yields quotient all-ones and remainder
                                // req_a, and the cleared signs bypass the fix-up.
                                rem_q      <= '0;
                                quo_q      <= div_zero_d ? req_a : mag32(req_a, div_signed);
                                divisor_q  <= mag32(req_b, div_signed);
                                neg_quo_q  <= div_signed & ~div_zero_d & (req_a[XLEN-1] ^ req_b[XLEN-1]);
                                neg_rem_q  <= div_signed & ~div_zero_d & req_a[XLEN-1];
                                div_zero_q <= div_zero_d;
                                cnt_q      <= DIV_CNT_INIT;
                                state_q    <= MD_S_DIV;
                            end
                            MD_MTHI: hi_q <= req_a;
                            MD_MTLO: lo_q <= req_a;
                            default: ;
                        endcase
                    end
                end
                MD_S_MUL: begin
                    if (flush) begin
                        state_q <= MD_S_IDLE;
                    end else if (cnt_q == '0) begin
                        hi_q    <= prod_q[2*XLEN-1:XLEN];
                        lo_q    <= prod_q[XLEN-1:0];
                        done_q  <= 1'b1;
                        state_q <= MD_S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                MD_S_DIV: begin
                    if (flush) begin
                        state_q <= MD_S_IDLE;
                    end else begin
                        rem_q <= rem_chain[DIV_STEPS];
                        quo_q <= quo_chain[DIV_STEPS];
                        if (cnt_q == '0) begin
                            state_q <= MD_S_SIGN;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                MD_S_SIGN: begin
                    // Flush wins over the commit in this cycle.
                    if (!flush) begin
                        lo_q   <= div_zero_q ? DIV_ZERO_LO : (neg_quo_q ? (XLEN'(0) - quo_q) : quo_q);
                        hi_q   <= neg_rem_q ? (XLEN'(0) - rem_q) : rem_q;
                        done_q <= 1'b1;
                    end
                    state_q <= MD_S_IDLE;
                end
                default: state_q <= MD_S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != MD_S_IDLE);
    assign req_ready = (state_q == MD_S_IDLE) & ~flush;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
